tx_sweep_scheduler: RTL and testbench

//  Sequences the transmit beamformer through a steering sweep. For each steering step it loads
//  per-element delays (cycles) into the beamformer, gates the 40 kHz wave for a burst, then holds
//  a listen window for echoes before stepping. Sits between top-level control and the delay datapath.

---
 rtl/tx_beam_pkg.sv | 19 +
 rtl/sched_timer.sv | 32 +++
 rtl/tx_sweep_scheduler.sv | 162 ++++++++++++++++
 tb/tb_tx_sweep_scheduler.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_beam_pkg.sv
// Shared types and helpers for the transmit sweep scheduler.
// Holds the scheduler state encoding, the default delay width and the |step| helper.
package tx_beam_pkg;

  localparam int DELAY_W_DEF = 10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FIRE,
    LISTEN,
    STEP
  } sched_state_t;

  function automatic logic [31:0] abs_step(input logic signed [31:0] s);
    return s[31] ? -s : s;
  endfunction

endpackage

// File: rtl/sched_timer.sv
// Reloadable count-down timer shared by the burst and listen phases.
// A start pulse loads a length; done_o is high during the last cycle of that length.
module sched_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CNT_W-1:0] load_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic             run_q;

  // A new start always overrides a count still in flight (e.g. after an early echo).
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start_i) begin
      cnt_q <= load_i - 1'b1;
      run_q <= 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) run_q <= 1'b0;
      else             cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = run_q && (cnt_q == '0);

endmodule

// File: rtl/tx_sweep_scheduler.sv
// Steps the transmit beamformer through a steering sweep: load per-element delays,
// fire a burst, listen for echoes, then advance the inter-element delay.
module tx_sweep_scheduler
  import tx_beam_pkg::*;
#(
  parameter int NUM_TRANSMITTERS = 4,
  parameter int DELAY_W          = DELAY_W_DEF,
  parameter int MAX_STEP         = 40,
  parameter int STEP_INC         = 8,
  parameter int BURST_CYCLES     = 10000,
  parameter int LISTEN_CYCLES    = 500000
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 stop,
  input  logic                                 continuous,
  input  logic                                 echo_valid,
  output logic [NUM_TRANSMITTERS*DELAY_W-1:0]  delay_out,
  output logic                                 delay_load,
  output logic                                 tx_enable,
  output logic                                 listen_active,
  output logic signed [DELAY_W:0]              step_delay,
  output logic                                 step_done,
  output logic                                 sweep_done,
  output logic                                 busy
);

  localparam int IDX_W     = $clog2(NUM_TRANSMITTERS + 1);
  localparam int TIMER_MAX = (BURST_CYCLES > LISTEN_CYCLES) ? BURST_CYCLES : LISTEN_CYCLES;
  localparam int CNT_W     = $clog2(TIMER_MAX + 1);
  localparam int SUM_W     = DELAY_W + 2;
  localparam logic signed [DELAY_W:0] NEG_MAX = -((DELAY_W+1)'(MAX_STEP));

  if ((NUM_TRANSMITTERS - 1) * MAX_STEP >= (1 << DELAY_W)) begin : g_width_chk
    $error("tx_sweep_scheduler: DELAY_W too narrow for (NUM_TRANSMITTERS-1)*MAX_STEP");
  end

  sched_state_t              state_q;
  logic [IDX_W-1:0]          idx_q;
  logic [DELAY_W-1:0]        acc_q;
  logic                      delay_load_q, tx_enable_q, listen_active_q;
  logic                      step_done_q, sweep_done_q, busy_q, stop_latched_q;
  logic signed [DELAY_W:0]   step_delay_q;
  logic signed [SUM_W-1:0]   step_delay_d;

  logic [DELAY_W-1:0]        abs_s;
  logic [IDX_W-1:0]          wr_idx;
  logic                      load_we, load_last, timer_start, timer_done, stop_now, step_wrap;
  logic [CNT_W-1:0]          timer_load;

  assign abs_s        = DELAY_W'(abs_step(32'(step_delay_q)));
  // Negative steps write elements from N-1 down to 0 so the running sum starts at zero.
  assign wr_idx       = step_delay_q[DELAY_W] ? IDX_W'(NUM_TRANSMITTERS - 1) - idx_q : idx_q;
  assign load_we      = (state_q == LOAD) && (idx_q < IDX_W'(NUM_TRANSMITTERS));
  assign load_last    = (state_q == LOAD) && (idx_q == IDX_W'(NUM_TRANSMITTERS));
  assign timer_start  = load_last || ((state_q == FIRE) && timer_done);
  assign timer_load   = (state_q == LOAD) ? CNT_W'(BURST_CYCLES) : CNT_W'(LISTEN_CYCLES);
  assign stop_now     = stop_latched_q || stop;
  assign step_delay_d = SUM_W'(step_delay_q) + SUM_W'(STEP_INC);
  assign step_wrap    = step_delay_d > SUM_W'(MAX_STEP);

  sched_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .start_i (timer_start),
    .load_i  (timer_load),
    .done_o  (timer_done)
  );

  for (genvar gi = 0; gi < NUM_TRANSMITTERS; gi++) begin : g_elem
    logic [DELAY_W-1:0] elem_q;
    always_ff @(posedge clk) begin
      if (rst)                                        elem_q <= '0;
      else if (load_we && (wr_idx == IDX_W'(gi)))     elem_q <= acc_q;
    end
    assign delay_out[gi*DELAY_W +: DELAY_W] = elem_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      acc_q           <= '0;
      delay_load_q    <= 1'b0;
      tx_enable_q     <= 1'b0;
      listen_active_q <= 1'b0;
      step_done_q     <= 1'b0;
      sweep_done_q    <= 1'b0;
      busy_q          <= 1'b0;
      stop_latched_q  <= 1'b0;
      step_delay_q    <= NEG_MAX;
    end else begin
      delay_load_q <= 1'b0;
      step_done_q  <= 1'b0;
      sweep_done_q <= 1'b0;
      if ((state_q != IDLE) && stop) stop_latched_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            state_q      <= LOAD;
            step_delay_q <= NEG_MAX;
            idx_q        <= '0;
            acc_q        <= '0;
            busy_q       <= 1'b1;
          end
        end
        LOAD: begin
          if (load_last) begin
            state_q     <= FIRE;
            tx_enable_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
            acc_q <= acc_q + abs_s;
            if (idx_q == IDX_W'(NUM_TRANSMITTERS - 1)) delay_load_q <= 1'b1;
          end
        end
        FIRE: begin
          if (timer_done) begin
            state_q         <= LISTEN;
            tx_enable_q     <= 1'b0;
            listen_active_q <= 1'b1;
          end
        end
        LISTEN: begin
          if (timer_done || echo_valid) begin
            state_q         <= STEP;
            listen_active_q <= 1'b0;
            step_done_q     <= 1'b1;
          end
        end
        STEP: begin
          idx_q <= '0;
          acc_q <= '0;
          if (step_wrap) begin
            sweep_done_q <= 1'b1;
            step_delay_q <= NEG_MAX;
          end else begin
            step_delay_q <= step_delay_d[DELAY_W:0];
          end
          if ((step_wrap && continuous && !stop_now) || (!step_wrap && !stop_now)) begin
            state_q <= LOAD;
          end else begin
            state_q        <= IDLE;
            busy_q         <= 1'b0;
            stop_latched_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign delay_load    = delay_load_q;
  assign tx_enable     = tx_enable_q;
  assign listen_active = listen_active_q;
  assign step_delay    = step_delay_q;
  assign step_done     = step_done_q;
  assign sweep_done    = sweep_done_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_tx_sweep_scheduler.sv
// Scoreboard bench for tx_sweep_scheduler: directed sweeps push expected events,
// a negedge monitor pops and compares each delay load, burst, listen window and pulse.
module tb_tx_sweep_scheduler;

  localparam int N      = 4;
  localparam int DW     = 10;
  localparam int MAXS   = 40;
  localparam int INC    = 40;
  localparam int BURST  = 20;
  localparam int LISTEN = 50;

  localparam int EV_LOAD = 0, EV_BURST = 1, EV_LISTEN = 2, EV_STEPD = 3, EV_SWEEP = 4;
  localparam int SEL_BUSY = 0, SEL_TX = 1, SEL_LISTEN = 2, SEL_SWEEP = 3;

  logic clk = 1'b0;
  logic rst, start, stop, continuous, echo_valid;
  logic [N*DW-1:0]      delay_out;
  logic                 delay_load, tx_enable, listen_active, step_done, sweep_done, busy;
  logic signed [DW:0]   step_delay;

  always #5 clk = ~clk;

  tx_sweep_scheduler #(
    .NUM_TRANSMITTERS (N),
    .DELAY_W          (DW),
    .MAX_STEP         (MAXS),
    .STEP_INC         (INC),
    .BURST_CYCLES     (BURST),
    .LISTEN_CYCLES    (LISTEN)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stop          (stop),
    .continuous    (continuous),
    .echo_valid    (echo_valid),
    .delay_out     (delay_out),
    .delay_load    (delay_load),
    .tx_enable     (tx_enable),
    .listen_active (listen_active),
    .step_delay    (step_delay),
    .step_done     (step_done),
    .sweep_done    (sweep_done),
    .busy          (busy)
  );

  typedef struct {
    int          kind;
    logic [63:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  int   tx_len = 0, ls_len = 0, since_load = 100;
  logic prev_tx = 1'b0, prev_ls = 1'b0;

  function automatic string ev_name(input int k);
    case (k)
      EV_LOAD:   return "load";
      EV_BURST:  return "burst_len";
      EV_LISTEN: return "listen_len";
      EV_STEPD:  return "step_done";
      default:   return "sweep_done";
    endcase
  endfunction

  function automatic logic [63:0] load_val(input int s);
    logic [N*DW-1:0] d;
    int v;
    d = '0;
    for (int i = 0; i < N; i++) begin
      v = (s >= 0) ? i * s : (N - 1 - i) * (-s);
      d[i*DW +: DW] = DW'(v);
    end
    return 64'({(DW+1)'(s), d});
  endfunction

  function automatic logic pick(input int sel);
    case (sel)
      SEL_BUSY:   return busy;
      SEL_TX:     return tx_enable;
      SEL_LISTEN: return listen_active;
      default:    return sweep_done;
    endcase
  endfunction

  task automatic check(input string nm, input logic signed [63:0] got, input logic signed [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", nm, got, exp);
    end else begin
      $display("[TB] ok %s = %0d", nm, got);
    end
  endtask

  task automatic sb_check(input int kind, input logic [63:0] got);
    exp_t e;
    tests++;
    if (sb_q.size() == 0) begin
      fails++;
      $display("[TB] FAIL %s: unexpected event with value %0h, nothing expected", ev_name(kind), got);
    end else begin
      e = sb_q.pop_front();
      if (e.kind != kind || e.val !== got) begin
        fails++;
        $display("[TB] FAIL %s: got %s %0h, expected %s %0h",
                 ev_name(kind), ev_name(kind), got, ev_name(e.kind), e.val);
      end else begin
        $display("[TB] ok %s %0h", ev_name(kind), got);
      end
    end
  endtask

  task automatic push_step(input int s, input int llen, input bit last);
    sb_q.push_back('{EV_LOAD,   load_val(s)});
    sb_q.push_back('{EV_BURST,  64'(BURST)});
    sb_q.push_back('{EV_LISTEN, 64'(llen)});
    sb_q.push_back('{EV_STEPD,  64'(0)});
    if (last) sb_q.push_back('{EV_SWEEP, 64'(0)});
  endtask

  task automatic push_sweep();
    push_step(-40, LISTEN, 1'b0);
    push_step(0,   LISTEN, 1'b0);
    push_step(40,  LISTEN, 1'b1);
  endtask

  task automatic wait_for(input int sel, input logic lvl, input int budget, input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (pick(sel) !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (pick(sel) !== lvl) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s: timed out after %0d cycles, level still %0b, required %0b",
               nm, budget, pick(sel), lvl);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(posedge clk); #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
  endtask

  task automatic settle_and_drain(input string nm);
    repeat (3) @(negedge clk);
    check(nm, sb_q.size(), 0);
  endtask

  // Monitor: every DUT event is matched against the head of the scoreboard queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        tx_len = 0; ls_len = 0; prev_tx = 1'b0; prev_ls = 1'b0;
      end else begin
        if (delay_load) begin
          sb_check(EV_LOAD, 64'({step_delay, delay_out}));
          since_load = 0;
        end else if (since_load < 100) begin
          since_load++;
        end
        if (busy && tx_enable) begin
          if (!prev_tx) check("load_to_tx_gap", since_load, 1);
          tx_len++;
        end else if (busy && prev_tx) begin
          sb_check(EV_BURST, 64'(tx_len));
          tx_len = 0;
        end else begin
          tx_len = 0;
        end
        if (busy && listen_active) begin
          ls_len++;
        end else if (busy && prev_ls) begin
          sb_check(EV_LISTEN, 64'(ls_len));
          ls_len = 0;
        end else begin
          ls_len = 0;
        end
        if (step_done)  sb_check(EV_STEPD, 64'(0));
        if (sweep_done) sb_check(EV_SWEEP, 64'(0));
        prev_tx = tx_enable;
        prev_ls = listen_active;
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0; echo_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_delay_out",     delay_out, 0);
    check("reset_delay_load",    delay_load, 0);
    check("reset_tx_enable",     tx_enable, 0);
    check("reset_listen_active", listen_active, 0);
    check("reset_step_delay",    step_delay, -40);
    check("reset_step_done",     step_done, 0);
    check("reset_sweep_done",    sweep_done, 0);
    check("reset_busy",          busy, 0);

    // Single sweep; a second start mid-burst must be ignored.
    push_sweep();
    pulse_start();
    wait_for(SEL_TX, 1'b1, 200, "sweep1_tx_rise");
    pulse_start();
    wait_for(SEL_BUSY, 1'b0, 2000, "sweep1_end");
    settle_and_drain("sweep1_queue_empty");

    // start and stop together in IDLE: stop wins.
    @(posedge clk); #1 start = 1'b1; stop = 1'b1;
    @(posedge clk); #1 start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);
    check("start_stop_idle_busy", busy, 0);

    // Early echo in listen cycle 10 of the first step.
    push_step(-40, 11, 1'b0);
    push_step(0,   LISTEN, 1'b0);
    push_step(40,  LISTEN, 1'b1);
    pulse_start();
    wait_for(SEL_LISTEN, 1'b1, 200, "echo_listen_rise");
    repeat (10) @(posedge clk);
    #1 echo_valid = 1'b1;
    @(posedge clk); #1 echo_valid = 1'b0;
    @(negedge clk);
    check("echo_listen_low", listen_active, 0);
    check("echo_step_done",  step_done, 1);
    wait_for(SEL_BUSY, 1'b0, 2000, "echo_sweep_end");
    settle_and_drain("echo_queue_empty");

    // Stop in FIRE cycle 5: burst and listen finish, then IDLE.
    push_step(-40, LISTEN, 1'b0);
    pulse_start();
    wait_for(SEL_TX, 1'b1, 200, "stop_tx_rise");
    repeat (5) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    wait_for(SEL_BUSY, 1'b0, 500, "stop_end");
    settle_and_drain("stop_queue_empty");
    check("stop_step_delay", step_delay, 0);

    // Continuous: wraps to -40 and reloads without a start.
    continuous = 1'b1;
    push_sweep();
    push_step(-40, LISTEN, 1'b0);
    pulse_start();
    wait_for(SEL_SWEEP, 1'b1, 2000, "cont_sweep_done");
    check("cont_busy_after_wrap",  busy, 1);
    check("cont_step_delay_wrap", step_delay, -40);
    wait_for(SEL_TX, 1'b1, 200, "cont_tx_rise");
    continuous = 1'b0;
    pulse_stop();
    wait_for(SEL_BUSY, 1'b0, 500, "cont_end");
    settle_and_drain("cont_queue_empty");

    // Reset during FIRE, then a full sweep again.
    push_step(-40, LISTEN, 1'b0);
    pulse_start();
    wait_for(SEL_TX, 1'b1, 200, "rst_tx_rise");
    repeat (3) @(posedge clk);
    #1 sb_q.delete();
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_tx_enable",  tx_enable, 0);
    check("midrst_busy",       busy, 0);
    check("midrst_listen",     listen_active, 0);
    check("midrst_delay_out",  delay_out, 0);
    check("midrst_step_delay", step_delay, -40);
    push_sweep();
    pulse_start();
    wait_for(SEL_BUSY, 1'b0, 2000, "post_rst_sweep_end");
    settle_and_drain("post_rst_queue_empty");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
